// File: rtl/vga_scanout.sv
// Pixel FIFO plus VGA-style scan timing. Output starts only after the FIFO has first filled.
// Optional build macro VGA_SCANOUT_TESTPATTERN_EN: underrun pixels show h_cnt ^ v_cnt instead of black.
`timescale 1ns/1ps
module vga_scanout #(
    parameter int H_ACTIVE   = 32,
    parameter int H_FP       = 2,
    parameter int H_SYNC     = 4,
    parameter int H_BP       = 2,
    parameter int V_ACTIVE   = 32,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       stb_i,
    output logic       ack_i,
    output logic       sync,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] rgb,
    output logic       underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [9:0]    h_cnt_reg;
    logic [9:0]    v_cnt_reg;
    logic [9:0]    h_cnt_next;
    logic [9:0]    v_cnt_next;

    logic       ack_reg;
    logic       sync_reg;
    logic       hsync_reg;
    logic       vsync_reg;
    logic       de_reg;
    logic [7:0] rgb_reg;
    logic       underrun_reg;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       active;
    logic       hs_zone;
    logic       vs_zone;
    logic [7:0] fill_pixel;

    // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign push    = stb_i && !ack_reg && !full;
    assign active  = (state_reg == RUN) && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    assign pop     = active && !empty;
    assign hs_zone = (h_cnt_reg >= H_SYNC_START) && (h_cnt_reg < H_SYNC_END);
    assign vs_zone = (v_cnt_reg >= V_SYNC_START) && (v_cnt_reg < V_SYNC_END);

`ifdef VGA_SCANOUT_TESTPATTERN_EN
    assign fill_pixel = h_cnt_reg[7:0] ^ v_cnt_reg[7:0];
`else
    assign fill_pixel = 8'h00;
`endif

    always_comb begin
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
        end else begin
            h_cnt_next = h_cnt_reg + 10'd1;
        end
    end

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FILL;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            h_cnt_reg    <= '0;
            v_cnt_reg    <= '0;
            ack_reg      <= 1'b0;
            sync_reg     <= 1'b0;
            hsync_reg    <= 1'b1;
            vsync_reg    <= 1'b1;
            de_reg       <= 1'b0;
            rgb_reg      <= 8'h00;
            underrun_reg <= 1'b0;
        end else begin
            ack_reg <= push;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);

            case (state_reg)
                FILL: begin
                    if (full) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    h_cnt_reg <= h_cnt_next;
                    v_cnt_reg <= v_cnt_next;
                    sync_reg  <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
                    hsync_reg <= !hs_zone;
                    vsync_reg <= !vs_zone;
                    de_reg    <= active;
                    if (!active) begin
                        rgb_reg <= 8'h00;
                    end else if (empty) begin
                        rgb_reg      <= fill_pixel;
                        underrun_reg <= 1'b1;
                    end else begin
                        rgb_reg <= mem[rd_ptr_reg];
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign ack_i    = ack_reg;
    assign sync     = sync_reg;
    assign hsync    = hsync_reg;
    assign vsync    = vsync_reg;
    assign de       = de_reg;
    assign rgb      = rgb_reg;
    assign underrun = underrun_reg;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Pixel sink at the far end of the PPU output stream: accepts 8-bit pixels over the stb/ack handshake into a small FIFO and scans them out with VGA-style hsync/vsync/de timing. It emits a one-cycle `sync` pulse at each frame start, which drives the PPU `sync` input. The timing generator is held until the FIFO is first full, so the first visible pixel is never an underrun.

## Interface
- `H_ACTIVE`, 32, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 2 / 4 / 2, horizontal front porch, sync width and back porch in clocks
- `V_ACTIVE`, 32, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 1 / 2 / 1, vertical porch and sync widths in lines
- `FIFO_DEPTH`, 4, FIFO entries; power of 2, at least 2
- `clk` in 1: the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `data_i` in 8: pixel, RRRGGGBB.
- `stb_i` in 1: source has valid `data_i`.
- `ack_i` out 1: one-cycle pulse; the beat was captured.
- `sync` out 1: one-cycle frame-start pulse.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `de` out 1: active-area pixel enable.
- `rgb` out 8: pixel out, RRRGGGBB.
- `underrun` out 1: sticky; active area was reached with the FIFO empty.

## Operation
- **Input capture:** `data_i` is pushed when `stb_i`=1, `ack_i`=0 and the FIFO is not full. The push registers `ack_i`=1 for exactly the next cycle.
  - While `ack_i`=1 no capture occurs, so a source holding `stb_i` through its ack cycle is captured once.
  - Full is evaluated before any same-cycle pop; a push is refused when full even if a pop occurs that cycle.
- **Counters:** `h_cnt` runs 0..H_TOTAL-1 and `v_cnt` runs 0..V_TOTAL-1, both 10 bits.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way. Both totals must be ≤1024.
  - `h_cnt` wraps to 0 and increments `v_cnt`; `v_cnt` wraps to 0 after V_TOTAL-1.
- **Region decode:**
  - Active: `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE.
  - hsync low: `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync low: `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line.
- **State machine:**
  - FILL: counters held at (0,0); all outputs stay at reset values except `ack_i`. When the FIFO count equals FIFO_DEPTH, go to RUN.
  - RUN: counters advance every cycle. The block never returns to FILL except through reset.
- **Pixel pop (RUN):** in the active region, one entry is popped per cycle and registered onto `rgb`.
  - If the FIFO is empty, `rgb` takes the underrun value and `underrun` sets; it stays set until reset.
  - Outside the active region, `rgb`=0x00 and nothing is popped.
- `sync` is 1 for the cycle in which the counters evaluate (0,0) in RUN, including the first RUN cycle.

## Timing
- **Reset (asynchronous, immediate):** `ack_i`=0, `sync`=0, `hsync`=1, `vsync`=1, `de`=0, `rgb`=0x00, `underrun`=0. FIFO is emptied, counters are 0, state is FILL.
- **Reset mid-frame:** the frame is abandoned and refill is required before output resumes.
- **Input latency:** `ack_i` rises 1 cycle after the capturing edge. Sustained input rate is at most 1 beat per 2 cycles.
- **Output latency:** `sync`, `hsync`, `vsync`, `de` and `rgb` are registered from the current counter values and appear 1 cycle after the counter state.
  - The first RUN cycle therefore yields `sync`=1, `de`=1 and `rgb`=first FIFO entry on the following edge.
- **Frame period:** H_TOTAL×V_TOTAL cycles between `sync` pulses; 40×36 = 1440 cycles with the defaults.

## Configuration
- `VGA_SCANOUT_TESTPATTERN_EN` defined: an underrun pixel outputs `h_cnt[7:0] ^ v_cnt[7:0]`.
- Not defined: an underrun pixel outputs 0x00.
- `underrun` sets in both builds.

## Test plan
- **Prefill:** push 0x11, 0x22, 0x33, 0x44, holding each `stb_i` until `ack_i` is seen.
  - Each push produces exactly one `ack_i` pulse.
  - `sync`/`de` stay 0 until the 4th capture; then `sync`=1 for one cycle.
  - `rgb` reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `de`=1.
- **Backpressure:** in RUN, hold `stb_i` during horizontal blanking with the FIFO full.
  - `ack_i` stays 0 until the first active-region pop.
  - No data is lost or duplicated.
- **Underrun:** stop feeding after prefill.
  - The 5th active pixel shows `rgb`=0x00, or h^v with the macro defined.
  - `underrun` goes to 1 and stays 1 through later frames.
- **Sync timing (defaults):**
  - `hsync` is low for 4 cycles starting 1 cycle after `h_cnt`=34.
  - `vsync` is low for 2 full lines.
  - `sync` pulses are exactly 1440 cycles apart.
- **Reset mid-frame:** assert `rst` asynchronously in the middle of line 10.
  - All outputs take reset values without waiting for a clock edge.
  - After release, no `sync` occurs until the FIFO is refilled with 4 entries.
- **Double-capture guard:** hold `stb_i`=1 with constant data for 6 cycles into an empty FIFO in FILL.
  - Exactly 3 captures occur, each followed by an `ack_i` pulse.
  - FIFO count reaches 3.
